// File: rtl/l2_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l2_arb_pkg
//  Description : Shared types, default widths and helpers for the L2 SRAM
//                arbiter (request/response records, one-hot decode).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package l2_arb_pkg;

    localparam int L2_ADDR_W = 32;
    localparam int L2_DATA_W = 32;

    // One requester's bus-side request record at the default widths.
    typedef struct packed {
        logic                   we;
        logic [L2_ADDR_W-1:0]   addr;
        logic [L2_DATA_W-1:0]   wdata;
        logic [L2_DATA_W/8-1:0] be;
        logic                   lock;
    } l2_req_t;

    // One requester's response record at the default widths.
    typedef struct packed {
        logic                 rvalid;
        logic                 rerr;
        logic [L2_DATA_W-1:0] rdata;
    } l2_rsp_t;

    // Index of the set bit in a one-hot vector of up to 8 requesters.
    // Returns 0 for an all-zero vector.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage : l2_arb_pkg
`default_nettype wire

// File: rtl/l2_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : l2_mem_arbiter_if
//  Description : Bus-side request/response ports plus the SRAM macro port of
//                the L2 arbiter, bundled into one interface.
//  Ports       : req_i/lock_i/we_i/addr_i/wdata_i/be_i  - requester inputs
//                gnt_o/rvalid_o/rerr_o/rdata_o          - requester outputs
//                mem_req_o/mem_we_o/mem_addr_o/
//                mem_wdata_o/mem_be_o                   - SRAM command
//                mem_rdata_i                            - SRAM read data
//                modport slave  : arbiter view
//                modport master : requesters + SRAM view
//  Revision    : 1.0 - initial release
// ============================================================================
interface l2_mem_arbiter_if #(
    parameter int N_REQ     = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 16384
);
    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int BE_W   = DATA_W / 8;

    logic [N_REQ-1:0]        req_i;
    logic [N_REQ-1:0]        lock_i;
    logic [N_REQ-1:0]        we_i;
    logic [N_REQ*ADDR_W-1:0] addr_i;
    logic [N_REQ*DATA_W-1:0] wdata_i;
    logic [N_REQ*BE_W-1:0]   be_i;
    logic [N_REQ-1:0]        gnt_o;
    logic [N_REQ-1:0]        rvalid_o;
    logic [N_REQ-1:0]        rerr_o;
    logic [DATA_W-1:0]       rdata_o;
    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [MEM_AW-1:0]       mem_addr_o;
    logic [DATA_W-1:0]       mem_wdata_o;
    logic [BE_W-1:0]         mem_be_o;
    logic [DATA_W-1:0]       mem_rdata_i;

    modport slave (
        input  req_i, lock_i, we_i, addr_i, wdata_i, be_i, mem_rdata_i,
        output gnt_o, rvalid_o, rerr_o, rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output req_i, lock_i, we_i, addr_i, wdata_i, be_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rerr_o, rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

endinterface : l2_mem_arbiter_if
`default_nettype wire

// File: rtl/l2_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : l2_arb_rr_pick
//  Description : Combinational round-robin picker. Searches req_i starting at
//                ptr_i (wrapping) and returns the first active requester.
//  Ports       : req_i    in  N_REQ   request vector
//                ptr_i    in  IDX_W   search start index
//                gnt_oh_o out N_REQ   one-hot pick
//                idx_o    out IDX_W   binary index of the pick
//                any_o    out 1       at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_arb_rr_pick
    import l2_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  wire logic [N_REQ-1:0] req_i,
    input  wire logic [IDX_W-1:0] ptr_i,
    output logic      [N_REQ-1:0] gnt_oh_o,
    output logic      [IDX_W-1:0] idx_o,
    output logic                  any_o
);

    logic [IDX_W-1:0] w_cand;
    logic [7:0]       w_oh8;

    always_comb begin
        gnt_oh_o = '0;
        any_o    = 1'b0;
        w_cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = IDX_W'((int'(ptr_i) + i) % N_REQ);
            if (!any_o && req_i[w_cand]) begin
                gnt_oh_o[w_cand] = 1'b1;
                any_o            = 1'b1;
            end
        end
    end

    always_comb begin
        w_oh8             = '0;
        w_oh8[N_REQ-1:0]  = gnt_oh_o;
        idx_o             = IDX_W'(onehot_to_idx(w_oh8));
    end

endmodule : l2_arb_rr_pick
`default_nettype wire

// File: rtl/l2_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : l2_mem_arbiter
//  Description : Shares one single-port L2 SRAM bank among N_REQ requesters
//                (requester 0 = JTAG debug bridge). Round-robin grant with a
//                per-requester burst lock capped at LOCK_MAX grants, address
//                range check with error response, one-cycle response stage.
//  Ports       : clk_i  in  system clock
//                rst_i  in  asynchronous active-high reset
//                bus    l2_mem_arbiter_if.slave (requester + SRAM ports)
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_mem_arbiter
    import l2_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int ADDR_W    = L2_ADDR_W,
    parameter int DATA_W    = L2_DATA_W,
    parameter int MEM_WORDS = 16384,
    parameter int LOCK_MAX  = 16
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    l2_mem_arbiter_if.slave   bus
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int CNT_W  = $clog2(LOCK_MAX + 1);
    localparam int BE_W   = DATA_W / 8;
    // One past the last legal byte address, one bit wider than the bus so
    // the comparison cannot overflow.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(64'(MEM_WORDS) * 64'd4);

    // ---------------------------------------------------------------- state
    logic [IDX_W-1:0] ptr_q,      ptr_d;
    logic             own_vld_q,  own_vld_d;
    logic [IDX_W-1:0] own_q,      own_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             rsp_vld_q,  rsp_vld_d;
    logic [IDX_W-1:0] rsp_idx_q,  rsp_idx_d;
    logic             rsp_err_q,  rsp_err_d;
    logic             rsp_rd_q,   rsp_rd_d;

    // ------------------------------------------------------- combinational
    logic [N_REQ-1:0]  w_rr_oh;
    logic [IDX_W-1:0]  w_rr_idx;
    logic              w_rr_any;
    logic              w_lock_hit;
    logic              w_gnt_any;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic [N_REQ-1:0]  w_gnt_oh;
    logic              w_sel_we;
    logic              w_sel_lock;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [BE_W-1:0]   w_sel_be;
    logic              w_in_range;
    logic              w_mem_req;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_unused_lsb;

    l2_arb_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (bus.req_i),
        .ptr_i    (ptr_q),
        .gnt_oh_o (w_rr_oh),
        .idx_o    (w_rr_idx),
        .any_o    (w_rr_any)
    );

    // Grant decision: a valid, still-requesting, still-locking owner under the
    // cap wins outright; otherwise round-robin from the pointer. Reset forces
    // every output low even while requests are held high.
    always_comb begin
        w_lock_hit = own_vld_q && bus.req_i[own_q] && bus.lock_i[own_q]
                     && (cnt_q < CNT_W'(LOCK_MAX));
        w_gnt_any  = !rst_i && (w_lock_hit || w_rr_any);
        w_gnt_idx  = w_lock_hit ? own_q : w_rr_idx;
        w_gnt_oh   = '0;
        if (w_gnt_any) begin
            if (w_lock_hit) begin
                w_gnt_oh[own_q] = 1'b1;
            end else begin
                w_gnt_oh = w_rr_oh;
            end
        end
    end

    // Mux the granted requester's command.
    always_comb begin
        w_sel_we    = bus.we_i[w_gnt_idx];
        w_sel_lock  = bus.lock_i[w_gnt_idx];
        w_sel_addr  = bus.addr_i[w_gnt_idx*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.wdata_i[w_gnt_idx*DATA_W +: DATA_W];
        w_sel_be    = bus.be_i[w_gnt_idx*BE_W +: BE_W];
        w_in_range  = {1'b0, w_sel_addr} < ADDR_LIMIT;
        w_mem_req   = w_gnt_any && w_in_range;
    end

    // Byte offset inside the word is intentionally ignored.
    assign w_unused_lsb = ^w_sel_addr[1:0];

    // Next-state: pointer, lock tracking, response stage.
    always_comb begin
        ptr_d      = ptr_q;
        own_vld_d  = own_vld_q;
        own_d      = own_q;
        cnt_d      = cnt_q;
        w_cnt_next = '0;
        rsp_vld_d  = w_gnt_any;
        rsp_idx_d  = w_gnt_idx;
        rsp_err_d  = w_gnt_any && !w_in_range;
        rsp_rd_d   = w_mem_req && !w_sel_we;

        if (w_gnt_any) begin
            ptr_d = (w_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            if (w_sel_lock) begin
                w_cnt_next = (own_vld_q && (own_q == w_gnt_idx)) ? cnt_q + 1'b1
                                                                 : CNT_W'(1);
                if (w_cnt_next >= CNT_W'(LOCK_MAX)) begin
                    // Cap reached: drop the lock so the pointer (already past
                    // the owner) gives everyone else one round.
                    own_vld_d = 1'b0;
                    own_d     = '0;
                    cnt_d     = '0;
                end else begin
                    own_vld_d = 1'b1;
                    own_d     = w_gnt_idx;
                    cnt_d     = w_cnt_next;
                end
            end else begin
                own_vld_d = 1'b0;
                own_d     = '0;
                cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            own_vld_q <= 1'b0;
            own_q     <= '0;
            cnt_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_idx_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_rd_q  <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            own_vld_q <= own_vld_d;
            own_q     <= own_d;
            cnt_q     <= cnt_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_idx_q <= rsp_idx_d;
            rsp_err_q <= rsp_err_d;
            rsp_rd_q  <= rsp_rd_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.gnt_o       = w_gnt_oh;
    assign bus.mem_req_o   = w_mem_req;
    assign bus.mem_we_o    = w_mem_req && w_sel_we;
    assign bus.mem_addr_o  = w_mem_req ? w_sel_addr[MEM_AW+1:2] : '0;
    assign bus.mem_wdata_o = w_mem_req ? w_sel_wdata : '0;
    assign bus.mem_be_o    = w_mem_req ? w_sel_be : '0;

    always_comb begin
        bus.rvalid_o = '0;
        bus.rerr_o   = '0;
        if (rsp_vld_q) begin
            bus.rvalid_o[rsp_idx_q] = 1'b1;
            bus.rerr_o[rsp_idx_q]   = rsp_err_q;
        end
    end

    // SRAM data is only forwarded for successful reads.
    assign bus.rdata_o = (rsp_vld_q && rsp_rd_q) ? bus.mem_rdata_i : '0;

endmodule : l2_mem_arbiter
`default_nettype wire

// File: doc/l2_mem_arbiter.md
Name: l2_mem_arbiter

Overview:
- Shares one single-port L2 SRAM bank between N_REQ masters: requester 0 is the JTAG debug bridge (pulp TAP write32/read32 path); the others are core/DMA ports.
- Round-robin arbitration with a per-requester burst lock, capped by a starvation limit.
- Address range check: out-of-range accesses never reach the SRAM and return an error response.
- Sits between the bus-side request ports and the SRAM macro, inside the jtagL2test top level.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; byte enables are DATA_W/8.
- MEM_WORDS, 16384, SRAM depth in words; legal byte addresses are 0 .. 4*MEM_WORDS-1.
- LOCK_MAX, 16, maximum consecutive grants to one locked requester before a forced release.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  N_REQ  per-requester request.
- lock_i  in  N_REQ  per-requester burst lock, meaningful only with req_i.
- we_i  in  N_REQ  1 = write, 0 = read.
- addr_i  in  N_REQ*ADDR_W  byte addresses, requester i at slice i.
- wdata_i  in  N_REQ*DATA_W  write data.
- be_i  in  N_REQ*DATA_W/8  byte enables.
- gnt_o  out  N_REQ  grant, combinational, same cycle as the request.
- rvalid_o  out  N_REQ  response valid, exactly one cycle after the grant.
- rerr_o  out  N_REQ  response error flag, qualified by rvalid_o.
- rdata_o  out  DATA_W  shared response data, qualified by rvalid_o.
- mem_req_o  out  1  SRAM chip enable.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  log2(MEM_WORDS)  SRAM word address, taken from addr[..:2].
- mem_wdata_o  out  DATA_W  SRAM write data.
- mem_be_o  out  DATA_W/8  SRAM byte enables.
- mem_rdata_i  in  DATA_W  SRAM read data, valid one cycle after mem_req_o.

Behaviour:
- Reset (async, rst_i=1): all outputs 0; priority pointer = 0; lock owner invalid; lock counter = 0; response pipeline cleared. Any in-flight response is discarded, so no rvalid_o appears after reset deasserts.
- Grant, at most one per cycle, decided combinationally:
  - Lock rule: if the lock owner is valid, its req_i and lock_i are high, and lock counter < LOCK_MAX, the owner is granted.
  - Otherwise: round-robin search starting at the priority pointer; the first requester with req_i high is granted.
  - After each grant the pointer becomes granted index + 1 (mod N_REQ).
- Lock tracking:
  - A grant with lock_i=1 sets the owner to that index and increments the counter.
  - Owner lock_i=0 or req_i=0 clears the owner and zeroes the counter.
  - When the counter reaches LOCK_MAX, the lock is released for one arbitration round: owner cleared, counter zeroed, pointer advanced past the owner. The requester may re-lock on its next grant.
- In-range grant: mem_req_o=1 with the granted requester's we/addr/wdata/be muxed through in the same cycle. mem_we_o=0 whenever mem_req_o=0.
- Out-of-range grant (addr >= 4*MEM_WORDS): gnt_o still asserts; mem_req_o stays 0.
- Misaligned addresses: addr[1:0] is ignored; the word is selected by addr[..:2].
- Response stage: registered granted index, valid flag and error flag. The cycle after a grant:
  - rvalid_o[idx]=1.
  - rdata_o = mem_rdata_i for a successful read; 0 for writes and for errors.
  - rerr_o[idx]=1 for out-of-range accesses.
- Throughput: back-to-back grants allowed, one access per cycle, zero bubbles. Requesters may change inputs after gnt_o.
- Idle: no req_i high → gnt_o=0, mem_req_o=0; pointer and lock are unchanged.
- A req_i that drops before being granted is simply not served; no state is affected.

Decomposition:
- Package l2_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - l2_req_t struct {we, addr, wdata, be, lock}.
  - l2_rsp_t struct {rvalid, rerr, rdata}.
  - Function onehot_to_idx.
- Sub-module l2_arb_rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: onehot grant, index, any.
  - Instantiated once. Lock override and all state stay in the parent.

Test Plan:
- Write then read, only req 0: write addr 0x0, data 0xABBAABBA, be 0xF; 50 idle cycles; read addr 0x0 → rvalid_o[0] one cycle after grant, rdata_o=0xABBAABBA, rerr_o=0.
- Contention, N_REQ=2, both requesters reading continuously, lock_i=0 → grants alternate 0,1,0,1…; pointer starts at 0 after reset.
- Lock cap, LOCK_MAX=16: req 1 locked burst writes to 0x100..0x17C while req 0 requests continuously → req 1 gets exactly 16 consecutive grants, then req 0 gets one, then req 1 resumes.
- Out of range: read at 4*MEM_WORDS (0x10000) → gnt_o=1, mem_req_o=0, next cycle rvalid_o=1, rerr_o=1, rdata_o=0. A following read of 0x0 is unaffected.
- Byte enables: write 0xFFFFFFFF to 0x8, then write 0x00000012 with be=0x1, read 0x8 → 0xFFFFFF12.
- Reset mid-op: assert rst_i in the cycle after a read grant → rvalid_o, gnt_o and mem_req_o all 0 immediately; after release the pointer is 0 and no stale rvalid_o appears.
